// File: rtl/img_pkg.sv
// Shared types for the image pixel sequencer.
// Holds the FSM state codes and the default pixel format.
package img_pkg;

   localparam int PIX_W_DEF = 24;

   typedef logic [PIX_W_DEF-1:0] pixel_t;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_REQ   = 4'd1,
      ST_WAIT  = 4'd2,
      ST_DRAIN = 4'd3,
      ST_DONE  = 4'd4,
      ST_ERR   = 4'd5
   } state_t;

endpackage

// File: rtl/pix_fifo.sv
// Show-ahead pixel FIFO: head is valid whenever not empty.
// Push and pop may happen in the same cycle; flush wins.
module pix_fifo
   import img_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = PIX_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] P_ONE   = AW'(1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;

   logic w_do_push;
   logic w_do_pop;

   assign empty     = (r_cnt == '0);
   assign full      = (r_cnt == C_DEPTH);
   assign count     = r_cnt;
   assign w_do_pop  = pop && !empty && !flush;
   assign w_do_push = push && !flush && (!full || w_do_pop);
   assign head      = empty ? '0 : r_mem[r_rd];

   // Storage array; contents only matter behind the pointers.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) begin
            r_wr <= r_wr + P_ONE;
         end
         if (w_do_pop) begin
            r_rd <= r_rd + P_ONE;
         end
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + C_ONE;
            2'b01:   r_cnt <= r_cnt - C_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/img_pix_sequencer.sv
// Moves one image from the pixel source to the CPU reader.
// One request in flight at a time, buffered in a show-ahead FIFO.
module img_pix_sequencer
   import img_pkg::*;
#(
   parameter int IMG_W      = 320,
   parameter int IMG_H      = 240,
   parameter int PIX_W      = PIX_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              get_next_pix,
   input  logic              pix_rdy,
   input  logic [PIX_W-1:0]  pixel_data,
   output logic              cpu_rdy,
   output logic [PIX_W-1:0]  pix_rgb_out,
   input  logic              cpu_ack,
   output logic              img_done,
   output logic [31:0]       pix_count,
   output logic [3:0]        out_state,
   output logic              timeout_err
);

   localparam int TOTAL = IMG_W * IMG_H;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] C_TOTAL = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
   localparam logic [TMR_W-1:0] C_TMO   = TMR_W'(TIMEOUT);
   localparam logic [TMR_W-1:0] T_ONE   = TMR_W'(1);
   localparam logic [AW:0]      C_DEPTH = (AW+1)'(FIFO_DEPTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_req_cnt;
   logic [CNT_W-1:0] r_pix_count;
   logic [TMR_W-1:0] r_timer;
   logic             r_timeout_err;

   logic             w_push;
   logic             w_pop;
   logic             w_flush;
   logic             w_restart;
   logic             w_space;
   logic             w_empty;
   logic             w_full;
   logic [AW:0]      w_fifo_cnt;
   logic [PIX_W-1:0] w_head;

   // A fresh image starts from IDLE or DONE; ERR resumes.
   assign w_restart = start && !abort &&
                      (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_space   = (w_fifo_cnt < C_DEPTH);
   assign w_pop     = cpu_ack && !w_empty && !abort &&
                      (r_state != ST_IDLE);
   assign w_push    = pix_rdy && !abort && (r_state == ST_WAIT) &&
                      (!w_full || w_pop);
   assign w_flush   = abort || w_restart;

   pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PIX_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (w_push),
      .pop   (w_pop),
      .flush (w_flush),
      .din   (pixel_data),
      .head  (w_head),
      .count (w_fifo_cnt),
      .empty (w_empty),
      .full  (w_full)
   );

   // Next-state decode; abort overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
               if (w_space) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               if (w_push) begin
                  w_state_nxt = (r_req_cnt == C_LAST) ?
                                ST_DRAIN : ST_REQ;
               end else if (r_timer == C_TMO) begin
                  w_state_nxt = ST_ERR;
               end
            end
            ST_DRAIN: begin
               if (w_empty && r_pix_count == C_TOTAL)
                  w_state_nxt = ST_DONE;
            end
            ST_DONE, ST_ERR: begin
               if (start) w_state_nxt = ST_REQ;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Request and delivery counters, cleared for each new image.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_req_cnt   <= '0;
         r_pix_count <= '0;
      end else if (w_flush) begin
         r_req_cnt   <= '0;
         r_pix_count <= '0;
      end else begin
         if (w_push) r_req_cnt   <= r_req_cnt + C_ONE;
         if (w_pop)  r_pix_count <= r_pix_count + C_ONE;
      end
   end

   // Source response timer; runs only while waiting in WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer <= '0;
      end else if (r_state == ST_WAIT && w_state_nxt == ST_WAIT) begin
         r_timer <= r_timer + T_ONE;
      end else begin
         r_timer <= '0;
      end
   end

   // Sticky timeout flag, cleared by abort or any accepted start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timeout_err <= 1'b0;
      end else if (abort) begin
         r_timeout_err <= 1'b0;
      end else if (start && (r_state == ST_IDLE ||
                             r_state == ST_DONE ||
                             r_state == ST_ERR)) begin
         r_timeout_err <= 1'b0;
      end else if (r_state == ST_WAIT && w_state_nxt == ST_ERR) begin
         r_timeout_err <= 1'b1;
      end
   end

   assign get_next_pix = (r_state == ST_REQ) && w_space && !abort;
   assign cpu_rdy      = !w_empty;
   assign pix_rgb_out  = w_head;
   assign img_done     = (r_state == ST_DONE);
   assign pix_count    = 32'(r_pix_count);
   assign out_state    = r_state;
   assign timeout_err  = r_timeout_err;

endmodule

// File: doc/img_pix_sequencer.md
# img_pix_sequencer

Sequences pixel transfer for one image from a pixel source (the SDRAM/frame-side reader) to the CPU-facing image reader. It issues one-at-a-time pixel requests and buffers returned pixels in a small show-ahead FIFO. It presents buffered pixels to the CPU with a ready/ack handshake, counts delivered pixels, and flags image completion or a source timeout. It sits between the pixel source and the HPS-visible image reader registers.

## Interface
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per image; TOTAL = IMG_W*IMG_H
- PIX_W, 24, RGB pixel width
- FIFO_DEPTH, 4, pixel buffer entries (power of two, ≥2)
- TIMEOUT, 1023, max cycles in WAIT before error
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin image transfer
- abort  in  1  one-cycle pulse: cancel transfer, flush buffer
- get_next_pix  out  1  one-cycle request strobe to pixel source
- pix_rdy  in  1  one-cycle strobe from source: pixel_data valid
- pixel_data  in  PIX_W  returned pixel
- cpu_rdy  out  1  FIFO non-empty; pix_rgb_out valid
- pix_rgb_out  out  PIX_W  FIFO head pixel
- cpu_ack  in  1  CPU consumed head pixel
- img_done  out  1  all TOTAL pixels delivered to CPU
- pix_count  out  32  pixels consumed by CPU this image
- out_state  out  4  current FSM state code
- timeout_err  out  1  sticky source-timeout flag

## Operation
- States/codes: IDLE=0, REQ=1, WAIT=2, DRAIN=3, DONE=4, ERR=5.
- IDLE: start → REQ; clears req_cnt, pix_count, timer, timeout_err; FIFO flushed.
- REQ: when fifo_count < FIFO_DEPTH, assert get_next_pix for exactly this cycle and go to WAIT; otherwise stay in REQ with get_next_pix=0.
- WAIT: timer increments each cycle. pix_rdy pushes pixel_data, req_cnt++, and clears the timer. Next state is DRAIN if req_cnt+1 == TOTAL, else REQ. If timer == TIMEOUT without pix_rdy, go to ERR.
- DRAIN: stay until FIFO empty and pix_count == TOTAL, then go to DONE.
- DONE: img_done=1; start → REQ with a fresh image (counters cleared as in IDLE).
- ERR: timeout_err=1 and no requests issued. The CPU may still drain the FIFO. start → REQ (clears flag); abort → IDLE.
- abort in any state: go to IDLE next cycle, flush FIFO, clear counters and timeout_err. abort has priority over start and pix_rdy in the same cycle.
- CPU side in every state except IDLE: cpu_ack with cpu_rdy=1 pops the head and increments pix_count. cpu_ack with cpu_rdy=0 is ignored.
- pix_rdy outside WAIT is ignored (no push, no count).
- start while in REQ/WAIT/DRAIN is ignored.
- At most one outstanding request; no request is issued unless the FIFO has a free slot.
- Counters are unsigned: req_cnt and pix_count wide enough for TOTAL, zero-extended to 32 bits on pix_count.

## Timing
- Reset values: get_next_pix=0, cpu_rdy=0, pix_rgb_out=0, img_done=0, pix_count=0, out_state=0, timeout_err=0; FIFO empty.
- start sampled at edge N → out_state=1 after N; get_next_pix high in the cycle after N (if space).
- The earliest legal pix_rdy is the cycle after get_next_pix.
- pix_rdy at edge M → cpu_rdy=1 and pix_rgb_out valid after M (1-cycle latency into show-ahead FIFO).
- Peak throughput is one pixel per 2 cycles (REQ+WAIT).
- Push and pop in the same cycle: fifo_count unchanged, both take effect. Pop of the last entry while pushing keeps cpu_rdy=1.
- Full FIFO (count == FIFO_DEPTH): FSM holds in REQ. Space frees on the cycle after pop; the request is issued in that cycle.
- img_done rises the cycle after the final pop in DRAIN. It stays high until start or abort.
- Timeout: ERR entered on the edge where timer == TIMEOUT, i.e. TIMEOUT+1 cycles after entering WAIT.
- Asynchronous reset mid-transfer: all state returns to reset values immediately; an in-flight pix_rdy is dropped.

## Structure
- Shared package img_pkg holds: state enum with the fixed 4-bit codes above, PIX_W default, and the pixel type.
- One sub-module, pix_fifo: synchronous show-ahead FIFO (depth FIFO_DEPTH, width PIX_W, ports push/pop/flush/count/empty/full/head).
- Total RTL is around 250 lines.

## Test plan
- Nominal: IMG_W=4, IMG_H=2, source responds 1 cycle after each request, CPU acks every cycle → 8 get_next_pix pulses, pixels 0x000001..0x000008 read in order, pix_count=8, img_done=1, out_state=4.
- Backpressure: FIFO_DEPTH=4, CPU never acks → exactly 4 requests, FSM holds in REQ. First ack → one further request within 2 cycles.
- Simultaneous push/pop: FIFO holding 1 entry, pix_rdy and cpu_ack in the same cycle → count stays 1, head becomes the new pixel, cpu_rdy remains 1.
- Timeout: TIMEOUT=15, source silent after the 3rd request → out_state=5 and timeout_err=1 after 16 WAIT cycles. The 2 buffered pixels are still drainable. start clears the flag.
- Abort: abort mid-image with 3 buffered pixels, and start in the same cycle → out_state=0, cpu_rdy=0, pix_count=0. A late pix_rdy is ignored.
- Reset mid-transfer: assert reset asynchronously in WAIT → all outputs at reset values without waiting for a clock edge. A new start runs a full 8-pixel image correctly.
